stack_access_controller: RTL and testbench
==========================================

STACK_ACCESS_CONTROLLER -- requirements
Module: stack_access_controller

Interface
REQ-001 Parameters SHALL be: DEPTH, default 300, number of stack words; WIDTH, default 32, data width; PTRW, default 9, stack-pointer width (2^PTRW > DEPTH).
REQ-002 Clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 Push  in  1  push request, sampled on a rising edge while Ready=1.
REQ-005 Pop  in  1  pop request, sampled on a rising edge while Ready=1.
REQ-006 PushData  in  WIDTH  word to push, sampled with Push.
REQ-007 Ready  out  1  controller idle and able to accept a request.
REQ-008 PopData  out  WIDTH  popped word, valid while PopValid=1.
REQ-009 PopValid  out  1  one-cycle pulse marking PopData valid.
REQ-010 Full / Empty  out  1 each  stack-pointer status.
REQ-011 Overflow / Underflow  out  1 each  sticky error flags.
REQ-012 StackPointer  out  PTRW  number of words currently stacked.
REQ-013 MemAddr  out  32  address to the memory, zero-extended from the pointer.
REQ-014 MemDataIn  out  WIDTH  write data to the memory.
REQ-015 MemWrite  out  1  memory write enable.
REQ-016 MemUseStk  out  1  selects the stack array of the memory; tied to 1 whenever MemWrite=1 or a read is in flight.
REQ-017 MemDataOut  in  WIDTH  registered read data from the memory, valid one edge after MemAddr is presented.

Function
REQ-018 FSM states SHALL be IDLE, WR, RD_WAIT and RD_CAP; Ready SHALL equal (state==IDLE).
REQ-019 All Mem* outputs, PopData and PopValid SHALL be registered.
REQ-020 Push accepted at edge E0 (IDLE, Push=1, Full=0) SHALL set MemAddr=StackPointer, MemDataIn=PushData, MemWrite=1, increment StackPointer and enter WR.
REQ-021 In WR, the next edge SHALL clear MemWrite and return to IDLE; push occupancy SHALL be exactly 1 cycle with Ready=0.
REQ-022 Pop accepted at E0 (IDLE, Pop=1, Push=0, Empty=0) SHALL set MemAddr=StackPointer-1, MemWrite=0, decrement StackPointer and enter RD_WAIT.
REQ-023 RD_WAIT SHALL advance to RD_CAP on the next edge (E1, memory latches the read).
REQ-024 At E2 (in RD_CAP), PopData SHALL capture MemDataOut, PopValid SHALL assert for exactly one cycle and the state SHALL return to IDLE; PopValid high in the cycle after E2.
REQ-025 Simultaneous Push and Pop in IDLE: Push SHALL take priority and Pop SHALL be discarded without setting any flag.
REQ-026 Push with Full=1 SHALL perform no memory access, leave StackPointer unchanged, set Overflow and stay in IDLE.
REQ-027 Pop with Empty=1 SHALL perform no memory access, produce no PopValid, set Underflow and stay in IDLE.
REQ-028 Requests while Ready=0 SHALL be ignored and not queued.
REQ-029 Full SHALL equal (StackPointer==DEPTH); Empty SHALL equal (StackPointer==0). Both are combinational from the pointer.
REQ-030 StackPointer SHALL never wrap and SHALL stay within 0..DEPTH.
REQ-031 Overflow and Underflow SHALL be cleared only by Reset.
REQ-032 PopData SHALL hold its last value until the next capture.

Reset
REQ-033 Reset=1 SHALL immediately, without waiting for Clock, force: state=IDLE, StackPointer=0, MemWrite=0, MemUseStk=0, MemAddr=0, MemDataIn=0, PopData=0, PopValid=0, Overflow=0, Underflow=0.
REQ-034 Reset asserted during WR or RD_* SHALL abort the operation: no PopValid, and MemWrite deasserts asynchronously.
REQ-035 After Reset deasserts, Ready=1 and Empty=1 from the first cycle.

Verification
REQ-036 Push 0xA5A5A5A5 after reset -> one cycle with MemWrite=1, MemAddr=0, MemUseStk=1; StackPointer=1; Ready low 1 cycle.
REQ-037 Push 0x11, push 0x22, pop, pop -> PopData 0x22 then 0x11; each PopValid 2 cycles after accept; final Empty=1.
REQ-038 Pop from empty -> Underflow=1, no PopValid, MemAddr unchanged; flag persists until Reset.
REQ-039 Push DEPTH words, then one more -> Full=1, StackPointer=300, Overflow=1, MemWrite not asserted for the extra push.
REQ-040 Push and Pop asserted together with StackPointer=3 -> push performed, StackPointer=4, no PopValid.
REQ-041 Reset asserted mid-pop (in RD_WAIT) -> StackPointer=0, no PopValid, Ready=1 after release.

Source files
------------

// File: rtl/stack_access_controller.sv
// stack_access_controller
// Moves a LIFO stack held in an external synchronous memory. It accepts one
// push or pop at a time and drives the memory port. A pop returns its word
// two edges after it is accepted.
//
// Ports
//   Clock, Reset      : rising-edge clock, asynchronous active-high reset
//   Push, Pop         : requests, sampled only while Ready=1 (Push wins a tie)
//   PushData          : word to push, sampled with Push
//   Ready             : controller idle (state==IDLE)
//   PopData, PopValid : popped word and its one-cycle valid strobe
//   Full, Empty       : pointer status, decoded from StackPointer
//   Overflow/Underflow: sticky error flags, cleared only by Reset
//   StackPointer      : number of words currently stacked
//   Mem*              : registered memory port; MemDataOut is registered
//                       read data, valid one edge after MemAddr is presented
module stack_access_controller #(
    parameter int unsigned DEPTH = 300,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PTRW  = 9
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Push,
    input  logic               Pop,
    input  logic [WIDTH-1:0]   PushData,
    output logic               Ready,
    output logic [WIDTH-1:0]   PopData,
    output logic               PopValid,
    output logic               Full,
    output logic               Empty,
    output logic               Overflow,
    output logic               Underflow,
    output logic [PTRW-1:0]    StackPointer,
    output logic [31:0]        MemAddr,
    output logic [WIDTH-1:0]   MemDataIn,
    output logic               MemWrite,
    output logic               MemUseStk,
    input  logic [WIDTH-1:0]   MemDataOut
);

    localparam int unsigned ADDRW = 32;
    localparam logic [PTRW-1:0] DEPTH_PTR = PTRW'(DEPTH);

    // The pointer must be able to hold DEPTH itself (the full count).
    if ((64'd1 << PTRW) <= 64'(DEPTH)) begin : g_bad_ptrw
        $error("stack_access_controller: PTRW too small for DEPTH");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_WAIT = 2'd2,
        RD_CAP  = 2'd3
    } state_t;

    state_t state;

    // Status decoded straight from the registered state and pointer.
    assign Ready = (state == IDLE);
    assign Full  = (StackPointer == DEPTH_PTR);
    assign Empty = (StackPointer == '0);

    // Control FSM with all memory-side and pop outputs registered.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            StackPointer <= '0;
            MemAddr      <= '0;
            MemDataIn    <= '0;
            MemWrite     <= 1'b0;
            MemUseStk    <= 1'b0;
            PopData      <= '0;
            PopValid     <= 1'b0;
            Overflow     <= 1'b0;
            Underflow    <= 1'b0;
        end else begin
            PopValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Push) begin
                        // Push has priority; a simultaneous Pop is dropped silently.
                        if (!Full) begin
                            MemAddr      <= ADDRW'(StackPointer);
                            MemDataIn    <= PushData;
                            MemWrite     <= 1'b1;
                            MemUseStk    <= 1'b1;
                            StackPointer <= StackPointer + PTRW'(1);
                            state        <= WR;
                        end else begin
                            Overflow <= 1'b1;
                        end
                    end else if (Pop) begin
                        if (!Empty) begin
                            MemAddr      <= ADDRW'(StackPointer - PTRW'(1));
                            MemWrite     <= 1'b0;
                            MemUseStk    <= 1'b1;
                            StackPointer <= StackPointer - PTRW'(1);
                            state        <= RD_WAIT;
                        end else begin
                            Underflow <= 1'b1;
                        end
                    end
                end
                WR: begin
                    // Memory has taken the write on this edge.
                    MemWrite  <= 1'b0;
                    MemUseStk <= 1'b0;
                    state     <= IDLE;
                end
                RD_WAIT: begin
                    // Memory latches the read address on this edge.
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    PopData   <= MemDataOut;
                    PopValid  <= 1'b1;
                    MemUseStk <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_access_controller.sv
// Self-checking bench for stack_access_controller: a synchronous memory
// model, a reference stack, and a queue of expected pop words that is
// compared whenever the DUT strobes PopValid.
module tb_stack_access_controller;

    localparam int unsigned DEPTH = 300;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned PTRW  = 9;

    logic               Clock = 1'b0;
    logic               Reset;
    logic               Push;
    logic               Pop;
    logic [WIDTH-1:0]   PushData;
    logic               Ready;
    logic [WIDTH-1:0]   PopData;
    logic               PopValid;
    logic               Full;
    logic               Empty;
    logic               Overflow;
    logic               Underflow;
    logic [PTRW-1:0]    StackPointer;
    logic [31:0]        MemAddr;
    logic [WIDTH-1:0]   MemDataIn;
    logic               MemWrite;
    logic               MemUseStk;
    logic [WIDTH-1:0]   MemDataOut;

    logic [WIDTH-1:0]   mem [0:511];
    logic [WIDTH-1:0]   modelStack [$];
    logic [WIDTH-1:0]   expQ [$];
    logic               prevPopValid = 1'b0;

    int testCount = 0;
    int failCount = 0;

    stack_access_controller #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .PTRW (PTRW)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Push        (Push),
        .Pop         (Pop),
        .PushData    (PushData),
        .Ready       (Ready),
        .PopData     (PopData),
        .PopValid    (PopValid),
        .Full        (Full),
        .Empty       (Empty),
        .Overflow    (Overflow),
        .Underflow   (Underflow),
        .StackPointer(StackPointer),
        .MemAddr     (MemAddr),
        .MemDataIn   (MemDataIn),
        .MemWrite    (MemWrite),
        .MemUseStk   (MemUseStk),
        .MemDataOut  (MemDataOut)
    );

    always #5 Clock = ~Clock;

    // Synchronous memory: write when enabled, registered read every edge.
    always @(posedge Clock) begin
        if (MemWrite && MemUseStk) mem[MemAddr[8:0]] <= MemDataIn;
        MemDataOut <= mem[MemAddr[8:0]];
    end

    task automatic checkValue(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard drain on every PopValid strobe.
    always @(negedge Clock) begin
        if (PopValid === 1'b1) begin
            checkValue("popvalid_pulse", 64'(prevPopValid), 64'(0));
            if (expQ.size() == 0)
                checkValue("unexpected_popvalid", 64'(1), 64'(0));
            else
                checkValue("pop_data", 64'(PopData), 64'(expQ.pop_front()));
        end
        prevPopValid = PopValid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic waitReady();
        int n = 0;
        while (Ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) checkValue("ready_timeout", 64'(0), 64'(1));
    endtask

    task automatic applyReset();
        Push  = 1'b0;
        Pop   = 1'b0;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        modelStack.delete();
        expQ.delete();
    endtask

    // Drives one push for the accepting edge; returns at E0+1.
    task automatic doPush(input logic [WIDTH-1:0] data);
        waitReady();
        Push     = 1'b1;
        PushData = data;
        tick();
        Push = 1'b0;
        if (modelStack.size() < DEPTH) modelStack.push_back(data);
    endtask

    // Drives one pop for the accepting edge; returns at E0+1.
    task automatic doPop();
        waitReady();
        Pop = 1'b1;
        tick();
        Pop = 1'b0;
        if (modelStack.size() > 0) expQ.push_back(modelStack.pop_back());
    endtask

    initial begin
        logic [31:0] addrSave;
        Reset    = 1'b1;
        Push     = 1'b0;
        Pop      = 1'b0;
        PushData = '0;
        for (int i = 0; i < 512; i++) mem[i] = '0;

        // Reset state, checked while Reset is still high.
        #3;
        checkValue("rst_ready",    64'(Ready),        64'(1));
        checkValue("rst_empty",    64'(Empty),        64'(1));
        checkValue("rst_sp",       64'(StackPointer), 64'(0));
        checkValue("rst_memwrite", 64'(MemWrite),     64'(0));
        checkValue("rst_usestk",   64'(MemUseStk),    64'(0));
        checkValue("rst_memaddr",  64'(MemAddr),      64'(0));
        checkValue("rst_popdata",  64'(PopData),      64'(0));
        checkValue("rst_flags",    64'({Overflow, Underflow, PopValid}), 64'(0));
        applyReset();
        checkValue("post_rst_ready", 64'(Ready), 64'(1));
        checkValue("post_rst_empty", 64'(Empty), 64'(1));

        // Single push: one write cycle at address 0, Ready low for one cycle.
        doPush(32'hA5A5_A5A5);
        checkValue("push_memwrite", 64'(MemWrite),     64'(1));
        checkValue("push_memaddr",  64'(MemAddr),      64'(0));
        checkValue("push_usestk",   64'(MemUseStk),    64'(1));
        checkValue("push_datain",   64'(MemDataIn),    64'(32'hA5A5_A5A5));
        checkValue("push_sp",       64'(StackPointer), 64'(1));
        checkValue("push_busy",     64'(Ready),        64'(0));
        tick();
        checkValue("push_wr_done",  64'(MemWrite),     64'(0));
        checkValue("push_ready",    64'(Ready),        64'(1));
        checkValue("push_usestk_off", 64'(MemUseStk),  64'(0));

        // Push 0x11, 0x22 then pop twice: LIFO order, PopValid two edges after accept.
        applyReset();
        doPush(32'h11);
        doPush(32'h22);
        doPop();
        checkValue("pop_addr",  64'(MemAddr),      64'(1));
        checkValue("pop_sp",    64'(StackPointer), 64'(1));
        checkValue("pop_pv_e0", 64'(PopValid),     64'(0));
        tick();
        checkValue("pop_pv_e1", 64'(PopValid),     64'(0));
        tick();
        checkValue("pop_pv_e2", 64'(PopValid),     64'(1));
        doPop();
        checkValue("pop2_addr", 64'(MemAddr),      64'(0));
        tick();
        tick();
        checkValue("pop2_pv_e2", 64'(PopValid),    64'(1));
        checkValue("pop2_data",  64'(PopData),     64'(32'h11));
        tick();
        checkValue("pop_final_empty", 64'(Empty),  64'(1));
        checkValue("popdata_hold",    64'(PopData), 64'(32'h11));

        // Pop from empty: sticky Underflow, no memory access, no PopValid.
        addrSave = MemAddr;
        doPop();
        checkValue("uflow_flag",  64'(Underflow), 64'(1));
        checkValue("uflow_addr",  64'(MemAddr),   64'(addrSave));
        checkValue("uflow_ready", 64'(Ready),     64'(1));
        checkValue("uflow_usestk", 64'(MemUseStk), 64'(0));
        tick();
        tick();
        checkValue("uflow_no_pv", 64'(PopValid),  64'(0));
        doPush(32'h33);
        tick();
        checkValue("uflow_sticky", 64'(Underflow), 64'(1));

        // Requests while busy are ignored: Push held across WR, Pop added in WR.
        waitReady();
        Push     = 1'b1;
        PushData = 32'h44;
        tick();
        modelStack.push_back(32'h44);
        Pop = 1'b1;
        tick();
        Push = 1'b0;
        Pop  = 1'b0;
        checkValue("busy_ignore_sp",    64'(StackPointer), 64'(2));
        checkValue("busy_ignore_ready", 64'(Ready),        64'(1));
        doPop();
        doPop();
        tick();
        tick();
        tick();

        // Push and Pop together with three stacked: push wins, Pop discarded.
        applyReset();
        doPush(32'h1);
        doPush(32'h2);
        doPush(32'h3);
        waitReady();
        Push     = 1'b1;
        Pop      = 1'b1;
        PushData = 32'h4;
        tick();
        Push = 1'b0;
        Pop  = 1'b0;
        modelStack.push_back(32'h4);
        checkValue("tie_sp",       64'(StackPointer), 64'(4));
        checkValue("tie_memwrite", 64'(MemWrite),     64'(1));
        checkValue("tie_memaddr",  64'(MemAddr),      64'(3));
        tick();
        tick();
        checkValue("tie_no_pv",    64'(PopValid),     64'(0));
        checkValue("tie_no_flags", 64'({Overflow, Underflow}), 64'(0));
        doPop();

        // Fill to DEPTH, then overflow.
        applyReset();
        for (int i = 0; i < DEPTH; i++) doPush(32'h1000 + 32'(i));
        waitReady();
        checkValue("full_flag", 64'(Full),         64'(1));
        checkValue("full_sp",   64'(StackPointer), 64'(DEPTH));
        doPush(32'hDEAD_BEEF);
        checkValue("oflow_memwrite", 64'(MemWrite),     64'(0));
        checkValue("oflow_flag",     64'(Overflow),     64'(1));
        checkValue("oflow_sp",       64'(StackPointer), 64'(DEPTH));
        checkValue("oflow_ready",    64'(Ready),        64'(1));
        doPop();
        doPop();
        tick();
        tick();
        tick();
        checkValue("after_full_sp",   64'(StackPointer), 64'(DEPTH - 2));
        checkValue("after_full_flag", 64'(Full),         64'(0));
        checkValue("oflow_sticky",    64'(Overflow),     64'(1));

        // Reset in RD_WAIT aborts the pop asynchronously.
        doPop();
        #2;
        Reset = 1'b1;
        #1;
        checkValue("abort_async_sp",     64'(StackPointer), 64'(0));
        checkValue("abort_async_usestk", 64'(MemUseStk),    64'(0));
        checkValue("abort_async_ready",  64'(Ready),        64'(1));
        expQ.delete();
        modelStack.delete();
        tick();
        tick();
        Reset = 1'b0;
        checkValue("abort_ready", 64'(Ready), 64'(1));
        checkValue("abort_empty", 64'(Empty), 64'(1));
        tick();
        tick();
        checkValue("abort_no_pv", 64'(PopValid),     64'(0));
        checkValue("abort_sp",    64'(StackPointer), 64'(0));
        checkValue("abort_flags", 64'({Overflow, Underflow}), 64'(0));

        tick();
        checkValue("sb_drain", 64'(expQ.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
